// File: rtl/uart_pkg.sv
// Frame-format constants and serialiser state encoding shared by the UART
// transmit and receive paths, so both ends agree on the frame format.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and count; full/empty are
// registered and decoded from the next count. rd_data always shows the head.
module uart_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == COUNT_FULL);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out
// LSB first on tx, paced by the shared oversampling baud_tick.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count,
    output logic                      overflow,
    output logic                      busy,
    output logic                      transmit_done,
    output logic                      tx
);

    localparam int unsigned   TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [TW-1:0]             tick_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] head;
    logic                      pop;

    assign pop = baud_tick && (state == IDLE) && !empty;

    uart_sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // tx is loaded one step ahead of each transition so the line is a pure flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            transmit_done <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            transmit_done <= 1'b0;
            overflow      <= wr_en && full;
            if (baud_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!empty) begin
                            shift    <= head;
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            tx       <= 1'b0;
                            busy     <= 1'b1;
                            state    <= START;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            tx       <= shift[0];
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                shift   <= shift >> 1;
                                tx      <= shift[1];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt      <= '0;
                            busy          <= 1'b0;
                            transmit_done <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a tick-domain line decoder recovers frames
// from tx and every observation is checked with an immediate assertion.
module tb_uart_tx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       baud_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       busy;
    logic       transmit_done;
    logic       tx;

    int compared = 0;
    int mismatched = 0;

    uart_tx_fifo #(
        .DEPTH(8),
        .OVERSAMPLE(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .busy         (busy),
        .transmit_done(transmit_done),
        .tx           (tx)
    );

    always #5 clock = ~clock;

    // One baud_tick every 4 clocks while enabled.
    bit tick_en = 1'b0;
    int div = 0;
    always @(negedge clock) begin
        if (tick_en) begin
            div = (div == 3) ? 0 : div + 1;
            baud_tick = (div == 3);
        end else begin
            div = 0;
            baud_tick = 1'b0;
        end
    end

    // Line log: one tx sample per tick (value held during the preceding period),
    // plus an independent receiver that samples each bit at its centre.
    bit         tlog[$];
    int         fall_q[$];
    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         frame_err = 0;
    int         rx_start = -1;
    int         m_idx;
    int         m_rel;
    int         m_bit;
    logic [7:0] rx_shift = 8'h00;

    always @(posedge clock) begin
        if (transmit_done) done_cnt++;
        if (!reset) begin
            rx_start = -1;
        end else if (baud_tick) begin
            tlog.push_back(tx);
            m_idx = tlog.size() - 1;
            if (rx_start < 0) begin
                if (m_idx > 0 && tlog[m_idx-1] == 1'b1 && tx == 1'b0) begin
                    rx_start = m_idx;
                    fall_q.push_back(m_idx);
                end
            end else begin
                m_rel = m_idx - rx_start;
                if ((m_rel % 16) == 8) begin
                    m_bit = m_rel / 16;
                    if (m_bit == 0) begin
                        if (tx !== 1'b0) frame_err++;
                    end else if (m_bit <= 8) begin
                        rx_shift[m_bit-1] = tx;
                    end else begin
                        if (tx !== 1'b1) frame_err++;
                        else rx_q.push_back(rx_shift);
                        rx_start = -1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && tlog.size() < n; i++) @(negedge clock);
        if (tlog.size() < n) check("log_timeout", 0, 1);
    endtask

    task automatic wait_ticks(input int n);
        wait_log(tlog.size() + n, n * 4 + 20);
    endtask

    task automatic wait_falls(input int n, input int budget);
        for (int i = 0; i < budget && fall_q.size() < n; i++) @(negedge clock);
        if (fall_q.size() < n) check("fall_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clock);
        if (rx_q.size() < n) check("rx_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && !(busy === 1'b0 && empty === 1'b1); i++) @(negedge clock);
        if (!(busy === 1'b0 && empty === 1'b1)) check("idle_timeout", 0, 1);
    endtask

    // Each of the 10 bit slots must hold its level for all 16 tick samples.
    task automatic check_frame(input int f, input logic [7:0] b);
        int  hits;
        logic e;
        wait_log(f + 161, 161 * 8);
        for (int bi = 0; bi < 10; bi++) begin
            if (bi == 0) e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else e = b[bi-1];
            hits = 0;
            for (int j = 0; j < 16; j++) begin
                if (f + 16 * bi + j < tlog.size() && tlog[f + 16 * bi + j] == e) hits++;
            end
            check($sformatf("frame_%02h_bit%0d_ticks", b, bi), hits, 16);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        int nr;
        int nd;
        int f;
        int lat;
        int stuck;

        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", transmit_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        reset = 1'b1;
        @(negedge clock);

        // Single frame 0xA5
        tick_en = 1'b1;
        repeat (10) @(negedge clock);
        nf = fall_q.size();
        nr = rx_q.size();
        nd = done_cnt;
        push(8'hA5);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("a5_tx_fall", tx, 0);
        check("a5_latency_le5", (lat <= 5), 1);
        check("a5_busy_with_fall", busy, 1);
        check("a5_count_after_pop", count, 0);
        wait_falls(nf + 1, 100);
        f = fall_q[nf];
        check_frame(f, 8'hA5);
        check("a5_idle_after_stop", tlog[f + 160], 1);
        wait_idle(100);
        check("a5_done_pulses", done_cnt - nd, 1);
        check("a5_busy_after", busy, 0);
        wait_rx(nr + 1, 100);
        check("a5_rx_byte", rx_q[nr], 8'hA5);

        // Fill to full, then overflow
        wait_idle(2000);
        tick_en = 1'b0;
        @(negedge clock);
        nr = rx_q.size();
        for (int i = 0; i < 8; i++) push(8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_no_ovf", overflow, 0);
        push(8'hFF);
        check("ovf_pulse", overflow, 1);
        check("ovf_count_kept", count, 8);
        @(negedge clock);
        check("ovf_one_cycle", overflow, 0);
        tick_en = 1'b1;
        wait_rx(nr + 8, 8 * 161 * 4 + 400);
        for (int i = 0; i < 8; i++) check($sformatf("fill_rx_%0d", i), rx_q[nr + i], i);
        wait_ticks(200);
        check("fill_no_extra_byte", rx_q.size(), nr + 8);
        check("fill_empty_end", empty, 1);
        check("fill_busy_end", busy, 0);

        // Back-to-back frames and count stepping
        wait_idle(2000);
        tick_en = 1'b0;
        @(negedge clock);
        nf = fall_q.size();
        nr = rx_q.size();
        push(8'h41);
        push(8'h54);
        push(8'h0D);
        check("b2b_count3", count, 3);
        check("b2b_not_empty", empty, 0);
        tick_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_falls(nf + k + 1, 1000);
            check($sformatf("b2b_count_step%0d", k), count, 2 - k);
        end
        wait_rx(nr + 3, 2000);
        check("b2b_rx0", rx_q[nr], 8'h41);
        check("b2b_rx1", rx_q[nr + 1], 8'h54);
        check("b2b_rx2", rx_q[nr + 2], 8'h0D);
        check("b2b_gap01", fall_q[nf + 1] - fall_q[nf], 161);
        check("b2b_gap12", fall_q[nf + 2] - fall_q[nf + 1], 161);

        // baud_tick frozen mid-START
        wait_idle(2000);
        nf = fall_q.size();
        nr = rx_q.size();
        push(8'h96);
        wait_falls(nf + 1, 200);
        f = fall_q[nf];
        tick_en = 1'b0;
        @(negedge clock);
        stuck = 0;
        repeat (100) begin
            @(negedge clock);
            if (tx !== 1'b0) stuck++;
        end
        check("freeze_tx_not_low", stuck, 0);
        check("freeze_busy", busy, 1);
        tick_en = 1'b1;
        check_frame(f, 8'h96);
        wait_rx(nr + 1, 200);
        check("freeze_rx", rx_q[nr], 8'h96);

        // Loopback bytes
        wait_idle(2000);
        tick_en = 1'b0;
        @(negedge clock);
        nr = rx_q.size();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        tick_en = 1'b1;
        wait_rx(nr + 3, 3 * 161 * 4 + 400);
        check("loop_rx_00", rx_q[nr], 8'h00);
        check("loop_rx_ff", rx_q[nr + 1], 8'hFF);
        check("loop_rx_55", rx_q[nr + 2], 8'h55);

        // Reset during DATA bit 4 of 0x3C with two bytes still queued
        wait_idle(2000);
        tick_en = 1'b0;
        @(negedge clock);
        nf = fall_q.size();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        tick_en = 1'b1;
        wait_falls(nf + 1, 200);
        f = fall_q[nf];
        wait_log(f + 88, 400);
        check("rst_mid_count_before", count, 2);
        check("rst_mid_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_count", count, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_full", full, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        nf = fall_q.size();
        nr = rx_q.size();
        wait_ticks(400);
        check("rst_no_new_frames", fall_q.size(), nf);
        check("rst_no_new_bytes", rx_q.size(), nr);
        check("rst_tx_idle", tx, 1);

        check("frame_errors", frame_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the HC-05 link: accepts bytes over a write strobe into an internal FIFO and serialises them 8N1, LSB first, on `tx`. It paces itself from the shared 16x-oversample `baud_tick` produced by `uart_baud_rate_generator`, the same tick `uart_rx` consumes. It replaces the unbuffered constant-byte transmit path, so logic upstream can queue multi-byte messages (e.g. AT command strings) without polling per byte.

## Interface
- `DEPTH`, 8, FIFO depth in bytes; power of two, ≥ 2
- `OVERSAMPLE`, 16, `baud_tick` pulses per bit period
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `baud_tick`  in  1  single-cycle pulse at OVERSAMPLE × baud rate
- `wr_en`  in  1  write strobe; byte captured on the rising edge when high and `full`=0
- `wr_data`  in  8  byte to queue
- `full`  out  1  FIFO holds DEPTH bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  $clog2(DEPTH+1)  bytes queued, excluding the byte being shifted
- `overflow`  out  1  one-cycle pulse: `wr_en` high while `full`=1, byte dropped
- `busy`  out  1  serialiser not in IDLE
- `transmit_done`  out  1  one-cycle pulse at the end of the stop bit
- `tx`  out  1  serial line, idle high

## Operation
- Reset values: `tx`=1, `busy`=0, `transmit_done`=0, `overflow`=0, `full`=0, `empty`=1, `count`=0; FIFO pointers cleared; state IDLE.
- FIFO: registered pointers and count. `full` and `empty` are registered and decoded from `count`.
- Write while full: ignored and `overflow` pulses, even if a pop happens in the same cycle. The writer must retry.
- Simultaneous write and pop while not full: both take effect and `count` is unchanged.
- Serialiser FSM (IDLE, START, DATA, STOP). Transitions occur only on cycles with `baud_tick`=1:
  - IDLE: if `empty`=0, pop the FIFO head into the shift register, clear the tick counter and bit index, then go to START.
  - START: `tx`=0 for OVERSAMPLE ticks, then go to DATA.
  - DATA: `tx`=shift[0]. Every OVERSAMPLE ticks, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for OVERSAMPLE ticks. Then pulse `transmit_done` and go to IDLE.
- `tx` is a registered output driven from the state and shift register. It carries no glitches.
- The tick counter is $clog2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE-1. The bit index is 3 bits.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously), the frame is abandoned and the FIFO is flushed.
- `baud_tick` held low: the FSM freezes in its current state and `tx` holds its value.

## Timing
- Latency from `wr_en` (when empty and IDLE) to the `tx` falling edge: 1 `clock` plus up to 1 `baud_tick` period plus 1 `clock`.
- Frame length: exactly 10 × OVERSAMPLE `baud_tick` pulses, measured from the IDLE→START tick to the STOP→IDLE tick.
- Back-to-back frames: the stop bit is followed by 1 `baud_tick` period of idle high (the IDLE pop tick). That gives 161 ticks per byte at the defaults.
- `count` decrements in the cycle after the IDLE→START tick.
- `busy` rises in the same cycle as `tx` falls. It drops in the same cycle `transmit_done` pulses.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP)
  - `UART_DATA_BITS`=8
  - `UART_OVERSAMPLE`=16
- `uart_pkg` is shared with `uart_rx` so both ends agree on frame format.
- One sub-module: `uart_sync_fifo` (parameterised width/depth; ports wr_en, wr_data, rd_en, rd_data, full, empty, count).
- The FSM, tick counter and shift register stay in `uart_tx_fifo`.

## Test plan
- Write 0xA5 while idle, `baud_tick` every 4 clocks → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; one `transmit_done` pulse; `busy` 0 afterwards.
- Write 8 bytes 0x00..0x07 in consecutive cycles, then a 9th byte 0xFF → `full`=1 after the 8th write; the 9th write raises `overflow` for 1 cycle; exactly bytes 0x00..0x07 appear on `tx` in order, and 0xFF never appears.
- Queue 0x41, 0x54, 0x0D → three frames, each separated by exactly 1 tick period of idle; `count` steps 3→2→1→0.
- Assert `reset` during DATA bit 4 of 0x3C with 2 bytes queued → `tx`=1 asynchronously, `count`=0, `empty`=1; no further frames after reset deasserts.
- Hold `baud_tick`=0 for 100 clocks mid-START → `tx` stays 0; the frame resumes with the remaining ticks intact when ticks restart.
- Loop `tx` into `uart_rx` with a shared `baud_tick`, send 0x00, 0xFF, 0x55 → `uart_rx` reports identical bytes.
